// File: rtl/alu_mux_sequencer_if.sv
// Command / result bus between the opcode decoder, the mux bank and alu_mux_sequencer.
// busy_cnt exists only when ALU_SEQ_BUSYCNT_EN is defined.
interface alu_mux_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             flush;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [3:0]       sel;
    logic [WIDTH-1:0] res_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_out;
`ifdef ALU_SEQ_BUSYCNT_EN
    logic [15:0]      busy_cnt;

    modport master (output flush, cmd_valid, cmd_op, res_in, res_ready,
                    input  cmd_ready, sel, res_valid, res_out, busy_cnt);
    modport slave  (input  flush, cmd_valid, cmd_op, res_in, res_ready,
                    output cmd_ready, sel, res_valid, res_out, busy_cnt);
`else
    modport master (output flush, cmd_valid, cmd_op, res_in, res_ready,
                    input  cmd_ready, sel, res_valid, res_out);
    modport slave  (input  flush, cmd_valid, cmd_op, res_in, res_ready,
                    output cmd_ready, sel, res_valid, res_out);
`endif
endinterface

// File: rtl/alu_mux_sequencer.sv
// Opcode FIFO + IDLE/EXEC/HOLD sequencer driving the shared 16:1 mux select and returning results.
// Optional EXEC-cycle counter on busy_cnt when ALU_SEQ_BUSYCNT_EN is defined.
module alu_mux_sequencer #(
    parameter int          WIDTH      = 16,
    parameter int          DEPTH      = 4,
    parameter logic [15:0] MULTI_MASK = 16'h0000,
    parameter int          MULTI_CYC  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_mux_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MULTI_CYC);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state_q, state_d;
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [3:0]       mem_q [DEPTH];
    logic [3:0]       sel_q, sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_out_q, res_out_d;
    logic             res_valid_q, res_valid_d;
    logic             empty, full, push, pop;
    logic [3:0]       head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus.cmd_valid && !full && !bus.flush;
    assign pop   = (state_q == IDLE) && !empty && !bus.flush;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign bus.cmd_ready = !full;
    assign bus.sel       = sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_out   = res_out_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.cmd_op;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    if (!empty)         state_d = EXEC;
                EXEC:    if (cnt_q == '0)    state_d = HOLD;
                HOLD:    if (bus.res_ready)  state_d = IDLE;
                default:                     state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; sel only changes on a pop or a flush.
    always_comb begin
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        res_out_d   = res_out_q;
        res_valid_d = res_valid_q;
        if (bus.flush) begin
            sel_d       = '0;
            cnt_d       = '0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (!empty) begin
                    sel_d = head;
                    cnt_d = MULTI_MASK[head] ? CW'(MULTI_CYC - 1) : '0;
                end
                EXEC: if (cnt_q == '0) begin
                    res_out_d   = bus.res_in;
                    res_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                HOLD: if (bus.res_ready) res_valid_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= '0;
            cnt_q       <= '0;
            res_out_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            res_out_q   <= res_out_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef ALU_SEQ_BUSYCNT_EN
    logic [15:0] busy_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       busy_cnt_q <= '0;
        else if (state_q == EXEC && busy_cnt_q != 16'hFFFF) busy_cnt_q <= busy_cnt_q + 16'd1;
    end

    assign bus.busy_cnt = busy_cnt_q;
`endif
endmodule
